// File: rtl/nanov_periph_pkg.sv
// Shared types, register bit positions and default addresses for the nanoV peripheral controller.
package nanov_periph_pkg;

  // One-hot register select, registered from the address phase.
  typedef enum logic [4:0] {
    SelNone  = 5'b00001,
    SelGpio  = 5'b00010,
    SelUart  = 5'b00100,
    SelUstat = 5'b01000,
    SelTimer = 5'b10000
  } sel_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxWaitBusy,
    TxWaitDone
  } tx_state_e;

  localparam int unsigned UstatFullBit    = 0;
  localparam int unsigned UstatRxValidBit = 1;
  localparam int unsigned UstatOvfBit     = 2;
  localparam int unsigned UstatTxIdleBit  = 3;

  localparam logic [31:0] GpioAddrDefault  = 32'h1000_0000;
  localparam logic [31:0] UartAddrDefault  = 32'h1000_1000;
  localparam logic [31:0] UstatAddrDefault = 32'h1000_1004;
  localparam logic [31:0] TimerAddrDefault = 32'h1000_2000;

  function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/nanov_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module nanov_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nanov_periph_ctrl.sv
// nanoV memory-mapped peripheral controller: address decode, read mux, GPIO, UART TX queue.
// Optional free-running timer register enabled by defining NANOV_PERIPH_TIMER_EN.
module nanov_periph_ctrl
  import nanov_periph_pkg::*;
#(
  parameter int unsigned TX_FIFO_DEPTH = 4,
  parameter logic [31:0] GPIO_ADDR     = GpioAddrDefault,
  parameter logic [31:0] UART_ADDR     = UartAddrDefault,
  parameter logic [31:0] USTAT_ADDR    = UstatAddrDefault,
  parameter logic [31:0] TIMER_ADDR    = TimerAddrDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_addr_valid_i,
  input  logic        cpu_data_valid_i,
  input  logic [31:0] cpu_data_out_i,
  output logic [31:0] cpu_data_in_o,
  input  logic [7:0]  gpio_in_i,
  output logic [7:0]  gpio_out_o,
  output logic        uart_tx_start_o,
  output logic [7:0]  uart_tx_data_o,
  input  logic        uart_tx_busy_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_read_o
);

  // Assert asynchronously, release on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  sel_e       sel_q, sel_d;
  tx_state_e  tx_state_q, tx_state_d;
  logic       wait_cnt_q, wait_cnt_d;
  logic [7:0] gpio_out_q, gpio_out_d;
  logic       ovf_q, ovf_d;
  logic       rx_read_q;
  logic [7:0] store_byte;
  logic       wr_gpio, wr_uart, wr_ustat;
  logic       ovf_set, tx_idle;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  always_comb begin
    sel_d = sel_q;
    if (cpu_addr_valid_i) begin
      if (cpu_data_out_i == GPIO_ADDR)       sel_d = SelGpio;
      else if (cpu_data_out_i == UART_ADDR)  sel_d = UartSel();
      else if (cpu_data_out_i == USTAT_ADDR) sel_d = SelUstat;
      else if (cpu_data_out_i == TIMER_ADDR) begin
`ifdef NANOV_PERIPH_TIMER_EN
        sel_d = SelTimer;
`else
        sel_d = SelNone;
`endif
      end else sel_d = SelNone;
    end
  end

  function automatic sel_e UartSel();
    return SelUart;
  endfunction

  // Store data arrives bit-reversed; the low byte sits in the top bits of the bus.
  assign store_byte = bit_reverse8(cpu_data_out_i[31:24]);
  assign wr_gpio    = cpu_data_valid_i && (sel_q == SelGpio);
  assign wr_uart    = cpu_data_valid_i && (sel_q == SelUart);
  assign wr_ustat   = cpu_data_valid_i && (sel_q == SelUstat);

  assign gpio_out_d = wr_gpio ? store_byte : gpio_out_q;
  assign ovf_set    = wr_uart && fifo_full && !fifo_pop;
  assign ovf_d      = ovf_set | (ovf_q & ~(wr_ustat & store_byte[UstatOvfBit]));

  nanov_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_sync_n),
    .push_i  (wr_uart),
    .pop_i   (fifo_pop),
    .wdata_i (store_byte),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // TX scheduler; WAIT_BUSY gives up after two cycles if the UART never raises busy.
  always_comb begin
    tx_state_d      = tx_state_q;
    wait_cnt_d      = 1'b0;
    uart_tx_start_o = 1'b0;
    fifo_pop        = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (!fifo_empty && !uart_tx_busy_i) begin
          uart_tx_start_o = 1'b1;
          fifo_pop        = 1'b1;
          tx_state_d      = TxWaitBusy;
        end
      end
      TxWaitBusy: begin
        wait_cnt_d = 1'b1;
        if (uart_tx_busy_i || wait_cnt_q) tx_state_d = TxWaitDone;
      end
      TxWaitDone: begin
        if (!uart_tx_busy_i) tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign uart_tx_data_o = fifo_rdata;
  assign tx_idle        = fifo_empty && (tx_state_q == TxIdle) && !uart_tx_busy_i;
  assign gpio_out_o     = gpio_out_q;
  assign uart_rx_read_o = rx_read_q;

`ifdef NANOV_PERIPH_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic        wr_timer;

  assign wr_timer = cpu_data_valid_i && (sel_q == SelTimer);
  assign timer_d  = wr_timer ? bit_reverse32(cpu_data_out_i) : timer_q + 32'd1;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) timer_q <= '0;
    else             timer_q <= timer_d;
  end
`endif

  always_comb begin
    cpu_data_in_o = '0;
    unique case (sel_q)
      SelGpio: cpu_data_in_o[7:0] = gpio_in_i;
      SelUart: cpu_data_in_o[7:0] = uart_rx_data_i;
      SelUstat: begin
        cpu_data_in_o[UstatFullBit]    = fifo_full;
        cpu_data_in_o[UstatRxValidBit] = uart_rx_valid_i;
        cpu_data_in_o[UstatOvfBit]     = ovf_q;
        cpu_data_in_o[UstatTxIdleBit]  = tx_idle;
      end
`ifdef NANOV_PERIPH_TIMER_EN
      SelTimer: cpu_data_in_o = timer_q;
`endif
      default: cpu_data_in_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      sel_q      <= SelNone;
      tx_state_q <= TxIdle;
      wait_cnt_q <= 1'b0;
      gpio_out_q <= '0;
      ovf_q      <= 1'b0;
      rx_read_q  <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      tx_state_q <= tx_state_d;
      wait_cnt_q <= wait_cnt_d;
      gpio_out_q <= gpio_out_d;
      ovf_q      <= ovf_d;
      rx_read_q  <= wr_uart;
    end
  end

endmodule
